// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing generator and image-store read sequencer.
//
// Pipeline, advancing only on ipix_ce:
//   counters (h,v) -> stage 0 decode (comb) -> address stage (oaddr_rd plus
//   delayed decode flags) -> output stage (ode/ord_en/ohsync/ovsync/oframe).
// The store sees oaddr_rd one pixel before ord_en rises, which hides its
// one-cycle read latency. Its colour output therefore lines up with this
// block's sync/de outputs.

module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_X    = 192,
  parameter int unsigned IMG_Y    = 120,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 240
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        ipix_ce,
  output logic [15:0] oaddr_rd,
  output logic        ord_en,
  output logic        ohsync,
  output logic        ovsync,
  output logic        ode,
  output logic        oframe
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WIN_X0     = 10'(IMG_X);
  localparam logic [9:0] WIN_X1     = 10'(IMG_X + IMG_W);
  localparam logic [9:0] WIN_Y0     = 10'(IMG_Y);
  localparam logic [9:0] WIN_Y1     = 10'(IMG_Y + IMG_H);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_scan_ctrl: line or frame total does not fit 10-bit counters");
  end

  if (IMG_W == 0 || IMG_H == 0) begin : g_bad_size
    $error("vga_scan_ctrl: image window must be non-empty");
  end

  if (IMG_X + IMG_W > H_ACTIVE || IMG_Y + IMG_H > V_ACTIVE) begin : g_bad_window
    $error("vga_scan_ctrl: image window must lie inside the active area");
  end

  if (IMG_W * IMG_H > 65536) begin : g_bad_area
    $error("vga_scan_ctrl: image window exceeds 16-bit address space");
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] hcnt_q;
  logic [9:0] vcnt_q;
  logic       h_last;
  logic       v_last;

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);

  // Horizontal/vertical position; vcnt steps when the line wraps.
  always_ff @(posedge iclk) begin
    if (irst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (ipix_ce) begin
      if (h_last) begin
        hcnt_q <= '0;
        vcnt_q <= v_last ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_q <= hcnt_q + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: decode of the current counter position
  // ---------------------------------------------------------------------------
  logic s0_act;
  logic s0_win;
  logic s0_hs;
  logic s0_vs;
  logic s0_first;

  // Pure decode of (hcnt, vcnt) into region flags.
  always_comb begin
    s0_act   = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
    s0_win   = (hcnt_q >= WIN_X0) && (hcnt_q < WIN_X1) &&
               (vcnt_q >= WIN_Y0) && (vcnt_q < WIN_Y1);
    s0_hs    = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    s0_vs    = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    s0_first = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  // ---------------------------------------------------------------------------
  // Address stage
  // ---------------------------------------------------------------------------
  logic [15:0] acnt_q;
  logic [15:0] addr_cur;
  logic        s1_act_q;
  logic        s1_win_q;
  logic        s1_hs_q;
  logic        s1_vs_q;
  logic        s1_first_q;

  // Frame start forces the address back to zero in the same pixel, so a
  // window touching (0,0) still starts at address 0.
  assign addr_cur = s0_first ? 16'd0 : acnt_q;

  // Row-major read address: a running count of window pixels this frame.
  always_ff @(posedge iclk) begin
    if (irst) begin
      acnt_q   <= '0;
      oaddr_rd <= '0;
    end else if (ipix_ce) begin
      if (s0_win) begin
        oaddr_rd <= addr_cur;
      end
      acnt_q <= addr_cur + {15'd0, s0_win};
    end
  end

  // Decode flags delayed to stay in step with oaddr_rd.
  always_ff @(posedge iclk) begin
    if (irst) begin
      s1_act_q   <= 1'b0;
      s1_win_q   <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_first_q <= 1'b0;
    end else if (ipix_ce) begin
      s1_act_q   <= s0_act;
      s1_win_q   <= s0_win;
      s1_hs_q    <= s0_hs;
      s1_vs_q    <= s0_vs;
      s1_first_q <= s0_first;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one pixel behind the address, matching store latency
  // ---------------------------------------------------------------------------

  // Registered sync/blank/gate outputs; syncs are active-low.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ode    <= 1'b0;
      ord_en <= 1'b0;
      ohsync <= 1'b1;
      ovsync <= 1'b1;
    end else if (ipix_ce) begin
      ode    <= s1_act_q;
      ord_en <= s1_win_q;
      ohsync <= ~s1_hs_q;
      ovsync <= ~s1_vs_q;
    end
  end

  // Frame pulse lasts one iclk even when ipix_ce is slower than iclk.
  always_ff @(posedge iclk) begin
    if (irst) begin
      oframe <= 1'b0;
    end else begin
      oframe <= ipix_ce & s1_first_q;
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Raster timing generator and read sequencer for the 8-bit image store.
- Produces 640x480 VGA sync/blank timing. Issues one read address per displayed pixel inside a rectangular image window.
- Drives the store's read address and read-enable inputs, aligned to its 1-cycle read latency, so the store's colour output can feed the DAC directly alongside this block's sync/de outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- IMG_X, 192, window left column
- IMG_Y, 120, window top line
- IMG_W, 256, window width in pixels
- IMG_H, 240, window height in lines (IMG_W*IMG_H <= 65536)

Ports:
- iclk  in  1  system clock
- irst  in  1  synchronous reset, active-high
- ipix_ce  in  1  pixel clock enable; all counters and outputs advance only when high
- oaddr_rd  out  16  read address to image store
- ord_en  out  1  read enable / output gate to image store, aligned with ohsync/ovsync/ode
- ohsync  out  1  horizontal sync, active-low
- ovsync  out  1  vertical sync, active-low
- ode  out  1  display enable (active video)
- oframe  out  1  one-iclk pulse on the first pixel of each frame

Behaviour:
- Reset: one clock, synchronous, active-high; iclk rising edge with irst=1.
  - hcnt=0, vcnt=0, address counter=0.
  - Outputs: oaddr_rd=0, ord_en=0, ode=0, ohsync=1, ovsync=1, oframe=0.
  - Reset wins over ipix_ce.
  - Reset mid-frame restarts at pixel (0,0) on the next ce.
- Counters (10-bit, registered, update only when ipix_ce=1):
  - hcnt counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800, then wraps to 0.
  - vcnt increments when hcnt wraps; counts 0..V_TOTAL-1 (525), then wraps to 0.
- Stage 0 (combinational from counters):
  - act = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - win = hcnt in [IMG_X, IMG_X+IMG_W) && vcnt in [IMG_Y, IMG_Y+IMG_H).
  - hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Address stage (registered on ce):
  - oaddr_rd <= acnt when win, else holds its last value.
  - acnt increments by 1 on each ce with win=1.
  - acnt resets to 0 on each ce at hcnt=0, vcnt=0.
  - Row-major, no multiplier; acnt reaches IMG_W*IMG_H-1 on the last window pixel.
  - 16-bit wrap is permitted only when IMG_W*IMG_H = 65536.
- Output stage (registered on ce, one pixel after the address stage):
  - ord_en = win delayed by one pixel.
  - ode = act delayed by one pixel.
  - ohsync = ~hs delayed by one pixel.
  - ovsync = ~vs delayed by one pixel.
  - The store samples oaddr_rd at least one iclk before ord_en rises, so its colour output is valid when ord_en=1.
- Latency: counter pixel (h,v) appears on ode/ohsync/ovsync/ord_en 2 ce-pixels after the counters equal (h,v).
  - All outputs share the same latency, so alignment holds.
- oframe: high for exactly one iclk, on the ce where the output stage presents pixel (0,0).
  - Low otherwise, including non-ce cycles.
- ipix_ce=0: all state and outputs hold; oframe=0.
- ipix_ce tied high: full-rate operation, 800x525 iclk per frame.
- Window at an active-area edge (e.g. IMG_X+IMG_W=H_ACTIVE): ord_en falls in the same cycle as ode; no read issued outside the active area.
- Parameter sanity: window must lie entirely inside the active area. Elaboration-time error otherwise.

Test Plan:
- Reset, then ipix_ce=1 for 1 frame -> ohsync low for 96 cycles per line starting 656+2 cycles after line start. ovsync low for 2 lines (1600 cycles). Line period 800, frame period 420000 cycles.
- Count ode=1 cycles per frame -> 307200. Count ord_en=1 cycles -> 61440. First ord_en at output pixel (192,120).
- Capture oaddr_rd on each address-stage window pixel -> sequence 0,1,...,61439 in order.
  - At the start of window line 2: 256.
  - Next frame restarts at 0.
- ipix_ce toggled 1-in-4 -> identical output sequence per ce. All outputs stable on non-ce cycles. oframe width 1 iclk.
- Assert irst for 1 cycle at hcnt=300, vcnt=200 -> next cycle shows reset values. Subsequent frame timing and addresses identical to the post-power-up run.
- Drive the image store from oaddr_rd/ord_en with ram[a]=a[7:0] -> DAC pixel at window (x,y) equals (y*256+x)[7:0] while ord_en=1. DAC output is 0 outside the window.
